c7seg_mux: RTL and testbench

//  Multi-digit, time-multiplexed 7-segment display driver for common-anode panels.

---
 rtl/c7seg_mux.sv | 151 +++++++++++++++
 tb/tb_c7seg_mux.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/c7seg_mux.sv
// c7seg_mux: time-multiplexed common-anode 7-segment driver with a decode back buffer and a scanned front buffer.
// Build option: define C7SEG_HEX_EN to show codes 10..15 as A,b,C,d,E,F instead of blank.
module c7seg_mux #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    output logic                  conv_wait,
    output logic [7:0]            seg_out,
    output logic [DIGITS-1:0]     dig_sel
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = $clog2(PRESCALE);
    localparam logic [IW-1:0]     LAST_IDX  = IW'(DIGITS - 1);
    localparam logic [PW-1:0]     LAST_TICK = PW'(PRESCALE - 1);
    localparam logic [DIGITS-1:0] ONE_HOT0  = DIGITS'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        SWAP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [IW-1:0]   idx;
    logic [3:0]      nib_sh [DIGITS];
    logic [DIGITS-1:0] dp_sh;
    logic [7:0]      back  [DIGITS];
    logic [7:0]      front [DIGITS];

    logic [PW-1:0]   presc;
    logic [IW-1:0]   scan_idx;

    // Active-high gfedcba glyph; unknown codes stay dark so only the DP can light.
    function automatic logic [6:0] glyph(input logic [3:0] code);
        logic [6:0] g;
        g = 7'h00;
        case (code)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
`ifdef C7SEG_HEX_EN
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            4'hF: g = 7'h71;
`else
            4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF: g = 7'h00;
`endif
            default: g = 7'h00;
        endcase
        return g;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (en) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = CONV;
            CONV:    if (idx == LAST_IDX) state_next = SWAP;
            SWAP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Busy for the whole CONV+SWAP window, which is exactly DIGITS+1 cycles.
    assign conv_wait = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            dp_sh <= '0;
            for (int i = 0; i < DIGITS; i++) begin
                nib_sh[i] <= 4'h0;
                back[i]   <= 8'hFF;
                front[i]  <= 8'hFF;
            end
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (load) begin
                        idx   <= '0;
                        dp_sh <= dp_in;
                        for (int i = 0; i < DIGITS; i++) begin
                            nib_sh[i] <= data_in[4*i +: 4];
                        end
                    end
                end
                CONV: begin
                    back[idx] <= ~{dp_sh[idx], glyph(nib_sh[idx])};
                    if (idx != LAST_IDX) begin
                        idx <= idx + IW'(1);
                    end
                end
                SWAP: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        front[i] <= back[i];
                    end
                end
                default: ;
            endcase
        end
    end

    // Scanning reads only the front buffer, so a frame in conversion never tears the display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc    <= '0;
            scan_idx <= '0;
            seg_out  <= 8'hFF;
            dig_sel  <= '1;
        end else if (en) begin
            if (presc == LAST_TICK) begin
                presc    <= '0;
                scan_idx <= (scan_idx == LAST_IDX) ? '0 : scan_idx + IW'(1);
            end else begin
                presc <= presc + PW'(1);
            end
            seg_out <= front[scan_idx];
            dig_sel <= ~(ONE_HOT0 << scan_idx);
        end else begin
            seg_out <= 8'hFF;
            dig_sel <= '1;
        end
    end

endmodule

// File: tb/tb_c7seg_mux.sv
// tb_c7seg_mux: directed checks of the load/convert/swap handshake, digit scanning,
// enable freeze and asynchronous reset, with hand-computed segment codes.
module tb_c7seg_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        conv_wait;
    logic [7:0]  seg_out;
    logic [3:0]  dig_sel;

    logic        load1;
    logic [3:0]  data1;
    logic [0:0]  dp1;
    logic        wait1;
    logic [7:0]  seg1;
    logic [0:0]  dig1;

    int num_compared   = 0;
    int num_mismatched = 0;

    logic [3:0] walk [4];

    always #5 clk = ~clk;

    c7seg_mux #(.DIGITS(4), .PRESCALE(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .load      (load),
        .data_in   (data_in),
        .dp_in     (dp_in),
        .conv_wait (conv_wait),
        .seg_out   (seg_out),
        .dig_sel   (dig_sel)
    );

    c7seg_mux #(.DIGITS(1), .PRESCALE(2)) dut_one (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .load      (load1),
        .data_in   (data1),
        .dp_in     (dp1),
        .conv_wait (wait1),
        .seg_out   (seg1),
        .dig_sel   (dig1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        num_compared++;
        if (actual !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Presents a load request for one cycle; returns at the sample after the accepting edge.
    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dp);
        load    = 1'b1;
        data_in = d;
        dp_in   = dp;
        @(negedge clk);
        load    = 1'b0;
    endtask

    task automatic countWait(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!conv_wait) break;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic waitForIdle();
        for (int i = 0; i < 20; i++) begin
            if (!conv_wait) break;
            @(negedge clk);
        end
        checkOutput("idle", 32'(conv_wait), 32'd0);
    endtask

    task automatic checkDigit(input int d, input logic [7:0] expected);
        logic [3:0] target;
        target = ~(4'b0001 << d);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (dig_sel == target) break;
        end
        checkOutput($sformatf("sel%0d", d), 32'(dig_sel), 32'(target));
        checkOutput($sformatf("seg%0d", d), 32'(seg_out), 32'(expected));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         n;
        logic [3:0] prev;

        walk[0] = 4'hE;
        walk[1] = 4'hD;
        walk[2] = 4'hB;
        walk[3] = 4'h7;

        rst_n   = 1'b0;
        en      = 1'b1;
        load    = 1'b0;
        data_in = 16'h0000;
        dp_in   = 4'h0;
        load1   = 1'b0;
        data1   = 4'h0;
        dp1     = 1'b0;

        #12;
        checkOutput("rst_seg",  32'(seg_out),   32'hFF);
        checkOutput("rst_sel",  32'(dig_sel),   32'hF);
        checkOutput("rst_wait", 32'(conv_wait), 32'd0);
        checkOutput("rst_sel1", 32'(dig1),      32'd1);

        $display("[TB] scan walk with blank frame");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            checkOutput("walk_sel", 32'(dig_sel), 32'(walk[(k-1)/4]));
            checkOutput("walk_seg", 32'(seg_out), 32'hFF);
            checkOutput("one_sel",  32'(dig1),    32'd0);
        end

        $display("[TB] load 1234");
        applyStimulus(16'h1234, 4'h0);
        countWait(n);
        checkOutput("wait_len", 32'(n), 32'd5);
        checkDigit(0, 8'h99);
        checkDigit(1, 8'hB0);
        checkDigit(2, 8'hA4);
        checkDigit(3, 8'hF9);

        $display("[TB] single digit instance");
        load1 = 1'b1;
        data1 = 4'h7;
        dp1   = 1'b1;
        @(negedge clk);
        load1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!wait1) break;
            @(negedge clk);
        end
        checkOutput("one_idle", 32'(wait1), 32'd0);
        @(negedge clk);
        checkOutput("one_seg", 32'(seg1), 32'h78);
        checkOutput("one_sel2", 32'(dig1), 32'd0);

        $display("[TB] load during conversion is dropped");
        applyStimulus(16'h0000, 4'h0);
        @(negedge clk);
        checkOutput("busy2", 32'(conv_wait), 32'd1);
        applyStimulus(16'h8888, 4'hF);
        waitForIdle();
        @(negedge clk);
        checkOutput("no_requeue", 32'(conv_wait), 32'd0);
        checkDigit(0, 8'hC0);
        checkDigit(1, 8'hC0);
        checkDigit(2, 8'hC0);
        checkDigit(3, 8'hC0);

        $display("[TB] hex codes and decimal point");
        applyStimulus(16'h00AF, 4'b0001);
        waitForIdle();
`ifdef C7SEG_HEX_EN
        checkDigit(0, 8'h0E);
        checkDigit(1, 8'h88);
`else
        checkDigit(0, 8'h7F);
        checkDigit(1, 8'hFF);
`endif
        checkDigit(2, 8'hC0);
        checkDigit(3, 8'hC0);

        $display("[TB] freeze mid-conversion and mid-slot");
        prev = dig_sel;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dig_sel == 4'hE && prev != 4'hE) break;
            prev = dig_sel;
        end
        checkOutput("slot_start", 32'(dig_sel), 32'hE);
        applyStimulus(16'h5678, 4'h0);
        checkOutput("frz_busy", 32'(conv_wait), 32'd1);
        checkOutput("frz_sel0", 32'(dig_sel),   32'hE);
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("frz_seg",  32'(seg_out),   32'hFF);
            checkOutput("frz_sel",  32'(dig_sel),   32'hF);
            checkOutput("frz_wait", 32'(conv_wait), 32'd1);
        end
        en = 1'b1;
        @(negedge clk);
        checkOutput("res_sel_a", 32'(dig_sel),   32'hE);
        checkOutput("res_wait",  32'(conv_wait), 32'd1);
        @(negedge clk);
        checkOutput("res_sel_b", 32'(dig_sel), 32'hD);
        countWait(n);
        checkOutput("res_wait_left", 32'(n), 32'd2);
        checkDigit(0, 8'h80);
        checkDigit(3, 8'h92);

        $display("[TB] reset during conversion");
        applyStimulus(16'h1111, 4'hF);
        @(negedge clk);
        checkOutput("pre_rst_busy", 32'(conv_wait), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_seg",  32'(seg_out),   32'hFF);
        checkOutput("arst_sel",  32'(dig_sel),   32'hF);
        checkOutput("arst_wait", 32'(conv_wait), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checkOutput("post_rst_seg",  32'(seg_out),   32'hFF);
            checkOutput("post_rst_wait", 32'(conv_wait), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
